// File: rtl/leg_solver_if.sv
// leg_solver_if: request/result bundle for the leg solver.
//   start        requester -> solver  request strobe, taken only when idle
//   r_in, x_in   requester -> solver  hypotenuse and known leg (unsigned)
//   busy         solver -> requester  computation in flight
//   done         solver -> requester  one-cycle result strobe
//   err          solver -> requester  last request had x > r
//   y_out        solver -> requester  recovered leg
interface leg_solver_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] r_in;
  logic [WIDTH-1:0] x_in;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] y_out;

  modport master (
    output start, r_in, x_in,
    input  busy, done, err, y_out
  );

  modport slave (
    input  start, r_in, x_in,
    output busy, done, err, y_out
  );
endinterface

// File: rtl/leg_solver.sv
// leg_solver: recovers the second leg y = floor(sqrt(r^2 - x^2)) of a right
// triangle from its hypotenuse r and known leg x.  A sequential
// shift/subtract square root runs a fixed WIDTH iterations, giving a constant
// latency of WIDTH+3 enabled edges from accepted start to done.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   ena     global clock enable; all state holds while low
//   req_if  slave side of leg_solver_if (start/r_in/x_in in,
//           busy/done/err/y_out out)
module leg_solver #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  leg_solver_if.slave  req_if
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, SQUARE, DIFF, ITER, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d, x_q, x_d;
  logic [W2-1:0]    rsq_q, rsq_d, xsq_q, xsq_d;
  logic [W2-1:0]    num_q, num_d, res_q, res_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bad_q, bad_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [W2-1:0]    trial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      x_q     <= '0;
      rsq_q   <= '0;
      xsq_q   <= '0;
      num_q   <= '0;
      res_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      y_q     <= '0;
    end else if (ena) begin
      state_q <= state_d;
      r_q     <= r_d;
      x_q     <= x_d;
      rsq_q   <= rsq_d;
      xsq_q   <= xsq_d;
      num_q   <= num_d;
      res_q   <= res_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    x_d     = x_q;
    rsq_d   = rsq_q;
    xsq_d   = xsq_q;
    num_d   = num_q;
    res_d   = res_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    y_d     = y_q;
    trial   = res_q + b_q;

    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (req_if.start) begin
          r_d     = req_if.r_in;
          x_d     = req_if.x_in;
          busy_d  = 1'b1;
          state_d = SQUARE;
        end
      end
      SQUARE: begin
        rsq_d   = W2'(r_q) * W2'(r_q);
        xsq_d   = W2'(x_q) * W2'(x_q);
        state_d = DIFF;
      end
      DIFF: begin
        // A negative radicand is flagged and the root forced to run on zero.
        if (xsq_q > rsq_q) begin
          bad_d = 1'b1;
          num_d = '0;
        end else begin
          bad_d = 1'b0;
          num_d = rsq_q - xsq_q;
        end
        res_d   = '0;
        b_d     = W2'(1) << (W2 - 2);
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        // One root bit per edge; res converges to floor(sqrt(num)).
        if (num_q >= trial) begin
          num_d = num_q - trial;
          res_d = (res_q >> 1) + b_q;
        end else begin
          res_d = res_q >> 1;
        end
        b_d   = b_q >> 2;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        y_d     = bad_q ? '0 : res_q[WIDTH-1:0];
        err_d   = bad_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_if.busy  = busy_q;
  assign req_if.done  = done_q;
  assign req_if.err   = err_q;
  assign req_if.y_out = y_q;
endmodule

// File: tb/tb_leg_solver.sv
module tb_leg_solver;
  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] y;
    logic             e;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  leg_solver_if #(.WIDTH(WIDTH)) bus ();

  leg_solver #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .req_if (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: brute-force integer square root of r^2 - x^2.
  function automatic exp_t model(input int r, input int x);
    exp_t o;
    int   v, y;
    if (x > r) begin
      o.y = '0;
      o.e = 1'b1;
    end else begin
      v = r * r - x * x;
      y = 0;
      while ((y + 1) * (y + 1) <= v) y++;
      o.y = y[WIDTH-1:0];
      o.e = 1'b0;
    end
    return o;
  endfunction

  // Presents one request at the falling edge, lets the next rising edge take
  // it, then scrambles the inputs so the running job must ignore them.
  task automatic issue(input int r, input int x, input bit push);
    @(negedge clk);
    bus.start = 1'b1;
    bus.r_in  = r[WIDTH-1:0];
    bus.x_in  = x[WIDTH-1:0];
    if (push) exp_q.push_back(model(r, x));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.r_in  = WIDTH'($urandom);
    bus.x_in  = WIDTH'($urandom);
  endtask

  // Counts enabled-or-not rising edges until done is seen, bounded.
  task automatic wait_done(output int lat, output bit found);
    lat   = 0;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.r_in  = '0;
    bus.x_in  = '0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.err, bus.y_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 0", {bus.busy, bus.done, bus.err, bus.y_out});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset busy/done got %b expected 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_basic();
    int   rt[7] = '{5, 13, 10, 255, 255, 0, 7};
    int   xt[7] = '{3, 5, 3, 0, 255, 0, 0};
    int   lat;
    bit   found;
    exp_t e;
    for (int k = 0; k < 7; k++) begin
      issue(rt[k], xt[k], 1'b1);
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_busy_rise[%0d] got %b expected 1", k, bus.busy);
      end
      wait_done(lat, found);
      e = exp_q.pop_front();
      checks++;
      if (!found || lat != 11) begin
        errors++;
        $display("FAIL basic_latency[%0d] got %0d (found=%0b) expected 11", k, lat, found);
      end
      checks++;
      if (bus.y_out !== e.y || bus.err !== e.e || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL basic_result r=%0d x=%0d got y=%0d err=%b busy=%b expected y=%0d err=%b busy=0",
                 rt[k], xt[k], bus.y_out, bus.err, bus.busy, e.y, e.e);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b0 || bus.y_out !== e.y) begin
        errors++;
        $display("FAIL basic_done_pulse[%0d] done=%b y=%0d expected done=0 y=%0d", k, bus.done, bus.y_out, e.y);
      end
    end
  endtask

  task automatic test_err();
    int   lat;
    bit   found;
    exp_t e;
    issue(100, 200, 1'b1);
    wait_done(lat, found);
    e = exp_q.pop_front();
    checks++;
    if (!found || bus.err !== 1'b1 || bus.y_out !== e.y) begin
      errors++;
      $display("FAIL err_flag got err=%b y=%0d found=%0b expected err=1 y=0", bus.err, bus.y_out, found);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL err_hold got %b expected 1", bus.err);
    end
    issue(5, 4, 1'b1);
    wait_done(lat, found);
    e = exp_q.pop_front();
    checks++;
    if (!found || bus.err !== e.e || bus.y_out !== e.y) begin
      errors++;
      $display("FAIL err_clear got err=%b y=%0d expected err=%b y=%0d", bus.err, bus.y_out, e.e, e.y);
    end
  endtask

  task automatic test_back_to_back();
    int   rt[3] = '{5, 13, 10};
    int   xt[3] = '{3, 5, 3};
    int   lat;
    bit   found;
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.r_in  = rt[0][WIDTH-1:0];
    bus.x_in  = xt[0][WIDTH-1:0];
    exp_q.push_back(model(rt[0], xt[0]));
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k < 2) begin
        // Next pair is presented while the current job runs.
        bus.r_in = rt[k+1][WIDTH-1:0];
        bus.x_in = xt[k+1][WIDTH-1:0];
        exp_q.push_back(model(rt[k+1], xt[k+1]));
      end
      wait_done(lat, found);
      e = exp_q.pop_front();
      checks++;
      if (!found || lat != 11 || bus.y_out !== e.y || bus.err !== e.e) begin
        errors++;
        $display("FAIL b2b_result[%0d] lat=%0d y=%0d err=%b expected lat=11 y=%0d err=%b",
                 k, lat, bus.y_out, bus.err, e.y, e.e);
      end
      if (k == 2) bus.start = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== (k < 2) || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_reaccept[%0d] busy=%b done=%b expected busy=%0b done=0",
                 k, bus.busy, bus.done, (k < 2));
      end
    end
  endtask

  task automatic test_ena();
    int   lat;
    bit   found;
    exp_t e;
    issue(13, 5, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    ena = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL ena_hold busy=%b done=%b expected busy=1 done=0", bus.busy, bus.done);
    end
    ena = 1'b1;
    wait_done(lat, found);
    e = exp_q.pop_front();
    checks++;
    if (!found || lat != 6 || bus.y_out !== e.y) begin
      errors++;
      $display("FAIL ena_delay lat=%0d y=%0d expected lat=6 y=%0d", lat, bus.y_out, e.y);
    end
    issue(10, 3, 1'b1);
    wait_done(lat, found);
    e = exp_q.pop_front();
    ena = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!found || bus.done !== 1'b1 || bus.y_out !== e.y) begin
      errors++;
      $display("FAIL ena_done_hold done=%b y=%0d expected done=1 y=%0d", bus.done, bus.y_out, e.y);
    end
    ena = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL ena_done_release got %b expected 0", bus.done);
    end
  endtask

  task automatic test_async_reset();
    int   lat;
    bit   found;
    exp_t e;
    issue(255, 0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.err, bus.y_out} !== '0) begin
      errors++;
      $display("FAIL async_reset got %b expected 0", {bus.busy, bus.done, bus.err, bus.y_out});
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(lat, found);
    checks++;
    if (found) begin
      errors++;
      $display("FAIL reset_abort got done after %0d edges expected none", lat);
    end
    issue(5, 3, 1'b1);
    wait_done(lat, found);
    e = exp_q.pop_front();
    checks++;
    if (!found || lat != 11 || bus.y_out !== e.y || bus.err !== e.e) begin
      errors++;
      $display("FAIL post_reset lat=%0d y=%0d err=%b expected lat=11 y=%0d err=%b",
               lat, bus.y_out, bus.err, e.y, e.e);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_err();
    test_back_to_back();
    test_ena();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
